// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Walks the enabled inputs of a downstream 8:1 selector, holding each
//   enabled channel for DWELL clock cycles. A scan either makes a single
//   pass over the mask or wraps and rescans until stopped.
//
// Parameters
//   DWELL       cycles each selected channel is held (1..256)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   start       level; begins a scan from IDLE when stop=0 and mask!=0
//   stop        aborts a scan in progress (priority over advance)
//   continuous  1 = wrap and rescan forever, 0 = single pass
//   mask[7:0]   bit k enables channel k
//   sel[2:0]    registered channel select
//   valid       registered; high while sel addresses a scanned channel
//   busy        registered; high in SCAN
//   done        registered one-cycle pulse at the end of a single pass
//   pass_cnt    registered count of completed passes (wraps 255->0)
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt
);

  localparam logic [7:0] DLAST = 8'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [7:0] dcnt_q, dcnt_d;

  // Lowest set mask bit, used as the first channel of a new scan.
  logic [2:0] first_idx;
  always_comb begin
    first_idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (mask[i-1]) first_idx = 3'(i - 1);
    end
  end

  // Next enabled channel searching sel+1 .. sel+7 and finally sel itself.
  // 3'(8) truncates to 0, so the last probe lands back on sel.
  logic [2:0] next_idx;
  logic       next_found;
  always_comb begin
    logic [2:0] idx;
    next_idx   = sel_q;
    next_found = 1'b0;
    idx        = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = sel_q + 3'(i);
      if (!next_found && mask[idx]) begin
        next_found = 1'b1;
        next_idx   = idx;
      end
    end
  end

  // Advancing to an index at or below the current one means the search
  // wrapped past channel 7: that closes a pass.
  logic wrap;
  assign wrap = (next_idx <= sel_q);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_cnt_d = pass_cnt_q;
    dcnt_d     = dcnt_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop && (mask != '0)) begin
          state_d    = SCAN;
          sel_d      = first_idx;
          dcnt_d     = '0;
          pass_cnt_d = '0;
          busy_d     = 1'b1;
          valid_d    = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          dcnt_d  = '0;
        end else if (dcnt_q == DLAST) begin
          dcnt_d = '0;
          if (!next_found) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
          end else if (wrap) begin
            pass_cnt_d = pass_cnt_q + 8'd1;
            if (continuous) begin
              sel_d = next_idx;
            end else begin
              // Single pass finished: sel keeps the last scanned channel.
              state_d = IDLE;
              busy_d  = 1'b0;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            sel_d = next_idx;
          end
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_cnt_q <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_cnt_q <= pass_cnt_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign sel      = sel_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_cnt_q;

endmodule
